// File: rtl/cpu_run_ctrl_pkg.sv
// Shared types for the core run-control sequencer: FSM state encoding and width.
package cpu_run_ctrl_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    RESET = 2'd0,
    RUN   = 2'd1,
    HALT  = 2'd2,
    STEP  = 2'd3
  } run_state_t;

endpackage

// File: rtl/cpu_run_ctrl.sv
// Run-control sequencer: drives core clock enable and sync reset (free-run, halt, step, optional PC breakpoint via RUN_CTRL_BKPT_EN).
// Latency: one registered cycle from any input change to a state change; breakpoint gating of cpu_ce is combinational.
// Backpressure: none; inputs are debounced levels sampled every cycle, step presses during STEP are dropped.
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int RST_CYCLES = 16,
  parameter int STEP_LEN   = 1
) (
  input  logic               clk,
  input  logic               arst_n,
  input  logic               mode_manual,
  input  logic               step_btn,
  input  logic               rst_btn,
  input  logic [31:0]        pc,
  input  logic [31:0]        bp_addr,
  input  logic               bp_valid,
  output logic               cpu_ce,
  output logic               cpu_rst,
  output logic               halted,
  output logic [STATE_W-1:0] state
);

  localparam int CNT_MAX = (RST_CYCLES > STEP_LEN) ? RST_CYCLES : STEP_LEN;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] RST_LOAD  = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STEP_LOAD = CNT_W'(STEP_LEN - 1);

  run_state_t       state_q, state_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic             step_prev;
  logic             step_pulse;
  logic             bp_hit;

  assign step_pulse = step_btn & ~step_prev;

`ifdef RUN_CTRL_BKPT_EN
  logic bp_skip;

  // bp_skip lets the core resume from the breakpoint address without re-hitting it.
  assign bp_hit = (state_q == RUN) & bp_valid & (pc == bp_addr) & ~bp_skip;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      bp_skip <= 1'b0;
    end else if (!rst_btn && state_q == HALT && !mode_manual) begin
      bp_skip <= 1'b1;
    end else if (state_q == RUN && cpu_ce) begin
      bp_skip <= 1'b0;
    end
  end
`else
  logic unused_bp;
  assign unused_bp = ^{pc, bp_addr, bp_valid};
  assign bp_hit    = 1'b0;
`endif

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q   <= RESET;
      cnt_q     <= RST_LOAD;
      step_prev <= 1'b1;
    end else begin
      state_q   <= state_nxt;
      cnt_q     <= cnt_nxt;
      step_prev <= step_btn;
    end
  end

  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    if (rst_btn) begin
      state_nxt = RESET;
      cnt_nxt   = RST_LOAD;
    end else begin
      case (state_q)
        RESET: begin
          if (cnt_q == '0) state_nxt = mode_manual ? HALT : RUN;
          else             cnt_nxt   = cnt_q - CNT_W'(1);
        end
        RUN: begin
          if (mode_manual || bp_hit) state_nxt = HALT;
        end
        HALT: begin
          // Returning to free-run beats a coincident step press.
          if (!mode_manual) begin
            state_nxt = RUN;
          end else if (step_pulse) begin
            state_nxt = STEP;
            cnt_nxt   = STEP_LOAD;
          end
        end
        STEP: begin
          if (cnt_q == '0) state_nxt = HALT;
          else             cnt_nxt   = cnt_q - CNT_W'(1);
        end
      endcase
    end
  end

  assign cpu_rst = (state_q == RESET);
  assign halted  = (state_q == HALT);
  assign cpu_ce  = (state_q == RESET) | (state_q == STEP) | ((state_q == RUN) & ~bp_hit);
  assign state   = state_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: directed scenarios plus randomized inputs, checked every cycle against a behavioural model.
module tb_cpu_run_ctrl;
  localparam int RST_CYCLES = 16;
  localparam int STEP_LEN   = 4;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        mode_manual = 1'b0;
  logic        step_btn = 1'b0;
  logic        rst_btn = 1'b0;
  logic [31:0] pc = 32'h0;
  logic [31:0] bp_addr = 32'h0;
  logic        bp_valid = 1'b0;
  logic        cpu_ce, cpu_rst, halted;
  logic [1:0]  state;

  int errors = 0;
  int checks = 0;

  cpu_run_ctrl #(.RST_CYCLES(RST_CYCLES), .STEP_LEN(STEP_LEN)) dut (
    .clk(clk), .arst_n(arst_n), .mode_manual(mode_manual), .step_btn(step_btn),
    .rst_btn(rst_btn), .pc(pc), .bp_addr(bp_addr), .bp_valid(bp_valid),
    .cpu_ce(cpu_ce), .cpu_rst(cpu_rst), .halted(halted), .state(state)
  );

  always #4 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  // Model: mode 0=reset 1=run 2=halt 3=step; remaining-cycle counts are 1-based.
  int m_st;
  int rst_left;
  int step_left;
  bit m_prev;
  bit m_skip;

  function automatic bit m_hit();
`ifdef RUN_CTRL_BKPT_EN
    return (m_st == 1) && bp_valid && (pc == bp_addr) && !m_skip;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit m_ce();
    return (m_st == 0) || (m_st == 3) || ((m_st == 1) && !m_hit());
  endfunction

  task automatic model_reset();
    m_st = 0; rst_left = RST_CYCLES; step_left = 0; m_prev = 1'b1; m_skip = 1'b0;
  endtask

  task automatic model_step();
    bit pulse, ce_now, hit;
    if (!arst_n) begin
      model_reset();
      return;
    end
    hit    = m_hit();
    ce_now = m_ce();
    pulse  = step_btn && !m_prev;
    m_prev = step_btn;
    if (m_st == 1 && ce_now) m_skip = 1'b0;
    if (rst_btn) begin
      m_st = 0; rst_left = RST_CYCLES;
    end else begin
      case (m_st)
        0: begin
          rst_left--;
          if (rst_left == 0) m_st = mode_manual ? 2 : 1;
        end
        1: if (mode_manual || hit) m_st = 2;
        2: begin
          if (!mode_manual) begin
            m_st = 1; m_skip = 1'b1;
          end else if (pulse) begin
            m_st = 3; step_left = STEP_LEN;
          end
        end
        default: begin
          step_left--;
          if (step_left == 0) m_st = 2;
        end
      endcase
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic compare();
    chk("cpu_rst", 32'(cpu_rst), 32'(m_st == 0));
    chk("cpu_ce",  32'(cpu_ce),  32'(m_ce()));
    chk("halted",  32'(halted),  32'(m_st == 2));
    chk("state",   32'(state),   32'(m_st));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic assert_arst();
    arst_n = 1'b0;
    model_reset();
    #1;
    compare();
  endtask

  initial begin
    int n, b, total;
    model_reset();
    repeat (3) @(negedge clk);
    compare();
    chk("reset_state", 32'(state), 0);
    chk("reset_ce", 32'(cpu_ce), 1);
    chk("reset_halted", 32'(halted), 0);

    // Reset release in free-run mode.
    arst_n = 1'b1;
    n = 0;
    while (cpu_rst && n < 40) begin n++; tick(); end
    chk("rst_len", n, 16);
    chk("run_after_rst", 32'(state), 1);
    n = 0;
    repeat (20) begin tick(); n += int'(cpu_ce); end
    chk("run_ce_count", n, 20);

    // Halt, then three step presses.
    mode_manual = 1'b1;
    tick(); tick();
    chk("halt_entered", 32'(state), 2);
    total = 0;
    for (int p = 0; p < 3; p++) begin
      step_btn = 1'b1; tick(); step_btn = 1'b0;
      b = int'(cpu_ce);
      repeat (7) begin tick(); b += int'(cpu_ce); end
      chk("burst_len", b, 4);
      chk("halted_between", 32'(halted), 1);
      total += b;
    end
    chk("step_total", total, 12);

    // Step button held through reset release.
    step_btn = 1'b1;
    assert_arst();
    tick();
    arst_n = 1'b1;
    repeat (24) tick();
    chk("held_no_step", 32'(state), 2);
    step_btn = 1'b0; tick();
    chk("release_no_step", 32'(state), 2);
    step_btn = 1'b1; tick();
    chk("repress_step", 32'(state), 3);
    step_btn = 1'b0;
    repeat (6) tick();

    // Reset button mid-step.
    step_btn = 1'b1; tick(); step_btn = 1'b0; tick();
    rst_btn = 1'b1; tick(); rst_btn = 1'b0;
    chk("rst_in_step", 32'(state), 0);
    n = 0;
    while (cpu_rst && n < 40) begin n++; tick(); end
    chk("rst_len_after_step", n, 16);
    chk("steps_discarded", 32'(state), 2);
    n = 0;
    repeat (5) begin tick(); n += int'(cpu_ce); end
    chk("no_leftover_ce", n, 0);

    // Mode drop coincident with a step press.
    mode_manual = 1'b0; step_btn = 1'b1; tick();
    chk("mode_beats_step", 32'(state), 1);
    tick();
    chk("still_run", 32'(state), 1);
    step_btn = 1'b0; tick();

`ifdef RUN_CTRL_BKPT_EN
    bp_addr = 32'h40; bp_valid = 1'b1; pc = 32'h3c; tick();
    pc = 32'h40; #1;
    chk("bp_ce_gated", 32'(cpu_ce), 0);
    compare();
    mode_manual = 1'b1; tick();
    chk("bp_halt", 32'(state), 2);
    tick();
    mode_manual = 1'b0; tick();
    chk("bp_resume", 32'(state), 1);
    chk("bp_resume_ce", 32'(cpu_ce), 1);
    pc = 32'h44; tick();
    chk("bp_past", 32'(state), 1);
    pc = 32'h48; tick();
    bp_valid = 1'b0;
`endif

    // Randomized phase.
    bp_addr = 32'h40;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        assert_arst();
        repeat (int'($urandom_range(1, 3))) tick();
        arst_n = 1'b1;
      end
      if ($urandom_range(0, 39) == 0) mode_manual = ~mode_manual;
      if ($urandom_range(0, 4) == 0) step_btn = ~step_btn;
      rst_btn  = ($urandom_range(0, 99) == 0);
      bp_valid = 1'($urandom_range(0, 1));
      pc       = 32'h3c + 32'(4 * $urandom_range(0, 2));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
